// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the register-file read ports and the multiply/divide unit.
// The master drives the request side; the slave (the unit) drives status and HI/LO.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit holding results in architectural HI/LO registers.
// Operates on magnitudes and applies sign correction in a single trailing cycle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic           clk,
    input logic           Reset,
    mult_div_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Only MULT/DIV (op[0] = 0) work on magnitudes; unsigned ops keep raw operands.
    assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;

    // Multiply: upper half accumulates the multiplicand, multiplier retires from the bottom.
    assign mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opa_q} : '0);

    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opb_q};

    assign prod_fix = (sa_q ^ sb_q) ? -work_q : work_q;
    assign quo_fix  = (opb_q == '0) ? '1 :
                      ((sa_q ^ sb_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0]);
    assign rem_fix  = sa_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        work_d  = work_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = 5'd31;
                    op_d    = bus.op;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    opa_d   = a_mag;
                    opb_d   = b_mag;
                    work_d  = {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                end else begin
                    if (bus.mthi) hi_d = bus.a;
                    if (bus.mtlo) lo_d = bus.a;
                end
            end
            CALC: begin
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
                if (op_q[1]) begin
                    work_d = div_trial[WIDTH] ?
                             {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0} :
                             {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
                end else begin
                    work_d = {mul_sum, work_q[WIDTH-1:1]};
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            work_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            work_q  <= work_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
